bfloat_mult_pipe: RTL and testbench

Parametrised, fully pipelined floating-point multiplier. It is the successor to the single-cycle bfloat16 multiplier and adds:
- configurable exponent and mantissa widths
- round-to-nearest-even
- IEEE special-value handling (zero, inf, NaN, flush-to-zero)
- exception flags
- a valid/ready handshake with backpressure and a sideband tag

It sits in the MAC datapath between operand fetch and the accumulator.

---
 rtl/bfloat_mult_pipe.sv | 180 ++++++++++++++++++
 tb/tb_bfloat_mult_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfloat_mult_pipe.sv
// Three-stage floating-point multiplier (default bfloat16) with round-to-nearest-even,
// special-value handling, exception flags and a valid/ready handshake carrying a sideband tag.
module bfloat_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_c,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int PW  = 2 * MAN_W + 2;
    localparam int EW2 = EXP_W + 2;
    localparam logic [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_e;

    logic [2:0] vld_pipe_q;
    logic       advance;

    assign advance   = !vld_pipe_q[2] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe_q[2];

    always_ff @(posedge clk) begin
        if (rst)          vld_pipe_q <= '0;
        else if (advance) vld_pipe_q <= {vld_pipe_q[1:0], in_valid};
    end

    // ---------------- S1: unpack, classify, exponent sum, significand product
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    kind_e            kind1_d, kind1_q;
    logic             sign1_q;
    logic [EW2-1:0]   exp1_d, exp1_q;
    logic [PW-1:0]    prod1_d, prod1_q;
    logic [TAG_W-1:0] tag1_q;

    assign ea = in_a[W-2 -: EXP_W];
    assign eb = in_b[W-2 -: EXP_W];
    assign ma = in_a[MAN_W-1:0];
    assign mb = in_b[MAN_W-1:0];

    // Subnormals (E=0, M!=0) are flushed: they classify as plain zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (ma == '0);
    assign b_inf  = (&eb) && (mb == '0);
    assign a_nan  = (&ea) && (ma != '0);
    assign b_nan  = (&eb) && (mb != '0);

    always_comb begin
        kind1_d = K_NORM;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) kind1_d = K_NAN;
        else if (a_inf || b_inf)                                      kind1_d = K_INF;
        else if (a_zero || b_zero)                                    kind1_d = K_ZERO;
    end

    assign exp1_d  = {2'b00, ea} + {2'b00, eb} - BIAS;
    assign prod1_d = {{(MAN_W+1){1'b0}}, 1'b1, ma} * {{(MAN_W+1){1'b0}}, 1'b1, mb};

    always_ff @(posedge clk) begin
        if (rst) begin
            kind1_q <= K_NORM;
            sign1_q <= 1'b0;
            exp1_q  <= '0;
            prod1_q <= '0;
            tag1_q  <= '0;
        end else if (advance) begin
            kind1_q <= kind1_d;
            sign1_q <= in_a[W-1] ^ in_b[W-1];
            exp1_q  <= exp1_d;
            prod1_q <= prod1_d;
            tag1_q  <= in_tag;
        end
    end

    // ---------------- S2: normalise and round to nearest even
    logic [PW-1:0]    norm;
    logic [EW2-1:0]   exp_n, exp2_d, exp2_q;
    logic [MAN_W-1:0] man_t, man2_q;
    logic [MAN_W:0]   man_r;
    logic             guard, sticky, round_up;
    kind_e            kind2_q;
    logic             sign2_q, inexact2_q;
    logic [TAG_W-1:0] tag2_q;

    // A product below 2.0 is shifted up one place so both cases share the same bit slots.
    assign norm     = prod1_q[PW-1] ? prod1_q : (prod1_q << 1);
    assign exp_n    = exp1_q + {{(EW2-1){1'b0}}, prod1_q[PW-1]};
    assign man_t    = norm[PW-2 -: MAN_W];
    assign guard    = norm[MAN_W];
    assign sticky   = |norm[MAN_W-1:0];
    assign round_up = guard && (sticky || man_t[0]);
    assign man_r    = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    assign exp2_d   = exp_n + {{(EW2-1){1'b0}}, man_r[MAN_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            kind2_q    <= K_NORM;
            sign2_q    <= 1'b0;
            exp2_q     <= '0;
            man2_q     <= '0;
            inexact2_q <= 1'b0;
            tag2_q     <= '0;
        end else if (advance) begin
            kind2_q    <= kind1_q;
            sign2_q    <= sign1_q;
            exp2_q     <= exp2_d;
            man2_q     <= man_r[MAN_W-1:0];
            inexact2_q <= guard || sticky;
            tag2_q     <= tag1_q;
        end
    end

    // ---------------- S3: range check, pack, flags
    logic [W-1:0] c_d, c_q;
    logic [3:0]   flags_d, flags_q;
    logic [TAG_W-1:0] tag3_q;
    logic         ovf, unf;

    assign ovf = !exp2_q[EW2-1] && (exp2_q >= EMAX);
    assign unf = exp2_q[EW2-1] || (exp2_q == '0);

    always_comb begin
        c_d     = {sign2_q, exp2_q[EXP_W-1:0], man2_q};
        flags_d = {3'b000, inexact2_q};
        case (kind2_q)
            K_NAN: begin
                c_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                flags_d = 4'b1000;
            end
            K_INF: begin
                c_d     = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_d = 4'b0000;
            end
            K_ZERO: begin
                c_d     = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
                flags_d = 4'b0000;
            end
            default: begin
                if (ovf) begin
                    c_d     = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0101;
                end else if (unf) begin
                    c_d     = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
                    flags_d = 4'b0011;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= '0;
            flags_q <= '0;
            tag3_q  <= '0;
        end else if (advance) begin
            c_q     <= c_d;
            flags_q <= flags_d;
            tag3_q  <= tag2_q;
        end
    end

    assign out_c     = c_q;
    assign out_tag   = tag3_q;
    assign out_flags = flags_q;
endmodule

// File: tb/tb_bfloat_mult_pipe.sv
// Directed bench for bfloat_mult_pipe: a bfloat16 instance and an IEEE-half instance.
module tb_bfloat_mult_pipe;
    logic clk = 1'b0;
    logic rst;
    logic d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [15:0] d_in_a, d_in_b, d_out_c;
    logic [3:0]  d_in_tag, d_out_tag, d_out_flags;
    logic h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out_c;
    logic [3:0]  h_in_tag, h_out_tag, h_out_flags;

    int total = 0;
    int bad   = 0;

    // Hand-computed bfloat16 vectors: a, b, product, flags {inv, ovf, unf, inx}
    logic [15:0] va [8] = '{16'h3FC0, 16'h3F80, 16'h3F81, 16'h3F81, 16'h7F00, 16'h0080, 16'h7F80, 16'h0001};
    logic [15:0] vb [8] = '{16'h3FC0, 16'hC000, 16'h3F81, 16'h3FC0, 16'h4000, 16'h0080, 16'h0000, 16'h3F80};
    logic [15:0] vc [8] = '{16'h4010, 16'hC000, 16'h3F82, 16'h3FC2, 16'h7F80, 16'h0000, 16'h7FC0, 16'h0000};
    logic [3:0]  vf [8] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h5, 4'h3, 4'h8, 4'h0};

    always #5 clk = ~clk;

    bfloat_mult_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_a(d_in_a), .in_b(d_in_b), .in_tag(d_in_tag), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_c(d_out_c), .out_tag(d_out_tag), .out_flags(d_out_flags)
    );

    bfloat_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_half (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .out_c(h_out_c), .out_tag(h_out_tag), .out_flags(h_out_flags)
    );

    // Present one operand pair, then wait (bounded) for its result; lat counts edges from accept.
    task automatic run_op(input bit half, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] tag, output logic [15:0] c, output logic [3:0] t,
                          output logic [3:0] f, output int lat);
        @(posedge clk); #1;
        if (half) begin
            h_in_valid = 1'b1; h_in_a = a; h_in_b = b; h_in_tag = tag; h_out_ready = 1'b1;
        end else begin
            d_in_valid = 1'b1; d_in_a = a; d_in_b = b; d_in_tag = tag; d_out_ready = 1'b1;
        end
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        d_in_valid = 1'b0;
        lat = 1;
        while (!(half ? h_out_valid : d_out_valid) && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        c = half ? h_out_c : d_out_c;
        t = half ? h_out_tag : d_out_tag;
        f = half ? h_out_flags : d_out_flags;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if ({d_out_valid, d_out_c, d_out_tag, d_out_flags} !== 25'd0) begin
            $display("FAIL reset_outputs got=%h exp=0", {d_out_valid, d_out_c, d_out_tag, d_out_flags});
            bad++;
        end
        total++;
        if (d_in_ready !== 1'b1 || h_in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got=%b%b exp=11", d_in_ready, h_in_ready);
            bad++;
        end
        total++;
        if (h_out_valid !== 1'b0) begin
            $display("FAIL reset_half_valid got=%b exp=0", h_out_valid);
            bad++;
        end
    endtask

    task automatic test_basic;
        logic [15:0] c; logic [3:0] t, f; int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, va[i], vb[i], 4'(i + 1), c, t, f, lat);
            total++;
            if (lat !== 3) begin
                $display("FAIL basic_latency[%0d] got=%0d exp=3", i, lat);
                bad++;
            end
            total++;
            if ({c, t, f} !== {vc[i], 4'(i + 1), vf[i]}) begin
                $display("FAIL basic_product[%0d] got c=%h tag=%h flags=%b exp c=%h tag=%h flags=%b",
                         i, c, t, f, vc[i], 4'(i + 1), vf[i]);
                bad++;
            end
        end
    endtask

    task automatic test_rounding;
        logic [15:0] c; logic [3:0] t, f; int lat;
        for (int i = 2; i < 4; i++) begin
            run_op(1'b0, va[i], vb[i], 4'(i), c, t, f, lat);
            total++;
            if ({c, f} !== {vc[i], vf[i]} || lat !== 3) begin
                $display("FAIL rounding[%0d] got c=%h flags=%b lat=%0d exp c=%h flags=%b lat=3",
                         i, c, f, lat, vc[i], vf[i]);
                bad++;
            end
        end
    endtask

    task automatic test_specials;
        logic [15:0] c; logic [3:0] t, f; int lat;
        for (int i = 4; i < 8; i++) begin
            run_op(1'b0, va[i], vb[i], 4'(i), c, t, f, lat);
            total++;
            if ({c, t, f} !== {vc[i], 4'(i), vf[i]} || lat !== 3) begin
                $display("FAIL special[%0d] got c=%h tag=%h flags=%b lat=%0d exp c=%h tag=%h flags=%b lat=3",
                         i, c, t, f, lat, vc[i], 4'(i), vf[i]);
                bad++;
            end
        end
    endtask

    // mode 0: out_ready always high; mode 1: out_ready cycles 1,0,0
    task automatic test_stream(input int mode);
        int sent, recv, done_cyc;
        logic prev_stall;
        logic [15:0] hc; logic [3:0] ht, hf;
        sent = 0; recv = 0; done_cyc = -1; prev_stall = 1'b0;
        hc = '0; ht = '0; hf = '0;
        for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
            @(posedge clk); #1;
            d_in_valid  = (sent < 8);
            d_in_a      = va[sent % 8];
            d_in_b      = vb[sent % 8];
            d_in_tag    = 4'(sent);
            d_out_ready = (mode == 0) || (cyc % 3 == 0);
            @(negedge clk);
            total++;
            if (d_in_ready !== !(d_out_valid && !d_out_ready)) begin
                $display("FAIL stream%0d_in_ready cyc=%0d got=%b valid=%b ready=%b", mode, cyc,
                         d_in_ready, d_out_valid, d_out_ready);
                bad++;
            end
            if (prev_stall) begin
                total++;
                if ({d_out_valid, d_out_c, d_out_tag, d_out_flags} !== {1'b1, hc, ht, hf}) begin
                    $display("FAIL stream%0d_stall_hold cyc=%0d got v=%b c=%h tag=%h exp v=1 c=%h tag=%h",
                             mode, cyc, d_out_valid, d_out_c, d_out_tag, hc, ht);
                    bad++;
                end
            end
            prev_stall = d_out_valid && !d_out_ready;
            hc = d_out_c; ht = d_out_tag; hf = d_out_flags;
            if (d_out_valid && d_out_ready) begin
                total++;
                if (recv >= 8) begin
                    $display("FAIL stream%0d_extra cyc=%0d got tag=%h exp none", mode, cyc, d_out_tag);
                    bad++;
                end else if ({d_out_c, d_out_tag, d_out_flags} !== {vc[recv], 4'(recv), vf[recv]}) begin
                    $display("FAIL stream%0d_result[%0d] got c=%h tag=%h flags=%b exp c=%h tag=%h flags=%b",
                             mode, recv, d_out_c, d_out_tag, d_out_flags, vc[recv], 4'(recv), vf[recv]);
                    bad++;
                end
                recv++;
                if (recv == 8) done_cyc = cyc;
            end
            if (d_in_valid && d_in_ready) sent++;
        end
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        total++;
        if (recv != 8) begin
            $display("FAIL stream%0d_count got=%0d exp=8", mode, recv);
            bad++;
        end
        if (mode == 0) begin
            total++;
            if (done_cyc != 10) begin
                $display("FAIL stream0_throughput got last_cycle=%0d exp=10", done_cyc);
                bad++;
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [15:0] c; logic [3:0] t, f; int lat; bit seen;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_in_valid = 1'b1; d_in_a = va[0]; d_in_b = vb[0]; d_in_tag = 4'(10 + i);
            @(posedge clk); #1;
        end
        d_in_valid = 1'b0;
        total++;
        if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0) begin
            $display("FAIL midrst_full got valid=%b in_ready=%b exp valid=1 in_ready=0", d_out_valid, d_in_ready);
            bad++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (d_out_valid !== 1'b0) begin
            $display("FAIL midrst_valid got=%b exp=0", d_out_valid);
            bad++;
        end
        d_out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (d_out_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            $display("FAIL midrst_ghost got a result after reset exp none");
            bad++;
        end
        run_op(1'b0, va[0], vb[0], 4'd9, c, t, f, lat);
        total++;
        if ({c, t, f} !== {16'h4010, 4'd9, 4'h0} || lat !== 3) begin
            $display("FAIL midrst_next got c=%h tag=%h flags=%b lat=%0d exp c=4010 tag=9 flags=0000 lat=3",
                     c, t, f, lat);
            bad++;
        end
    endtask

    task automatic test_half;
        logic [15:0] c; logic [3:0] t, f; int lat;
        run_op(1'b1, 16'h3E00, 16'h3E00, 4'd3, c, t, f, lat);
        total++;
        if ({c, t, f} !== {16'h4080, 4'd3, 4'h0} || lat !== 3) begin
            $display("FAIL half_product got c=%h tag=%h flags=%b lat=%0d exp c=4080 tag=3 flags=0000 lat=3",
                     c, t, f, lat);
            bad++;
        end
        run_op(1'b1, 16'h7BFF, 16'h4000, 4'd5, c, t, f, lat);
        total++;
        if ({c, t, f} !== {16'h7C00, 4'd5, 4'h5} || lat !== 3) begin
            $display("FAIL half_overflow got c=%h tag=%h flags=%b lat=%0d exp c=7c00 tag=5 flags=0101 lat=3",
                     c, t, f, lat);
            bad++;
        end
    endtask

    initial begin
        rst = 1'b0;
        d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_tag = '0; d_out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_tag = '0; h_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_stream(0);
        test_stream(1);
        test_reset_midstream();
        test_half();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
